// File: rtl/sam_pkg.sv
// Shared SAMx4 definitions: the RATE input encodings, the I/O page constant and
// the divider codes reported on CUR_DIV.
package sam_pkg;

    localparam logic [1:0] RATE_SLOW  = 2'b00;
    localparam logic [1:0] RATE_ADDR  = 2'b01;
    localparam logic [1:0] RATE_FAST  = 2'b10;
    localparam logic [1:0] RATE_TURBO = 2'b11;

    localparam logic [7:0] IO_PAGE = 8'hFF;

    typedef enum logic [1:0] {
        DIV_CODE_SLOW  = 2'b00,
        DIV_CODE_FAST  = 2'b10,
        DIV_CODE_TURBO = 2'b11
    } div_code_t;

    // ROM and cartridge space run fast; RAM and the FFxx I/O page stay slow.
    function automatic div_code_t addr_div(input logic [7:0] addr_hi);
        return (addr_hi[7] && (addr_hi != IO_PAGE)) ? DIV_CODE_FAST : DIV_CODE_SLOW;
    endfunction

endpackage

// File: rtl/sam_ecq_gen_if.sv
// Rate request and clock-phase outputs shared between the E/Q generator and
// the CPU/DRAM sequencing logic.
interface sam_ecq_gen_if #(
    parameter int CW = 4
);
    logic [1:0]    RATE;
    logic [15:0]   A;
    logic          STRETCH;
    logic          E;
    logic          Q;
    logic          CYC_START;
    logic          CYC_END;
    logic [CW-1:0] PHASE;
    logic [1:0]    CUR_DIV;

    modport master (
        output RATE, A, STRETCH,
        input  E, Q, CYC_START, CYC_END, PHASE, CUR_DIV
    );

    modport slave (
        input  RATE, A, STRETCH,
        output E, Q, CYC_START, CYC_END, PHASE, CUR_DIV
    );
endinterface

// File: rtl/sam_rate_sel.sv
// Maps a requested RATE and CPU address to the divider code for a cycle;
// purely combinational so other schedulers can share it.
module sam_rate_sel
    import sam_pkg::*;
(
    input  logic [1:0]  rate,
    input  logic [15:0] addr,
    output div_code_t   div_code
);

    // Only the page byte selects the speed; the offset is deliberately ignored.
    logic addr_lo_unused;
    assign addr_lo_unused = ^addr[7:0];

    always_comb begin
        // NOTE: default assignment first so every path drives div_code and no latch is inferred.
        div_code = DIV_CODE_SLOW;
        case (rate)
            RATE_ADDR:  div_code = addr_div(addr[15:8]);
            RATE_FAST:  div_code = DIV_CODE_FAST;
            RATE_TURBO: div_code = DIV_CODE_TURBO;
            default:    div_code = DIV_CODE_SLOW;
        endcase
    end

endmodule

// File: rtl/sam_ecq_gen.sv
// 6809 E/Q quadrature clock generator: phase counter, stretch hold, divider
// latch and registered clock outputs, all on the rising edge of OSCOut.
module sam_ecq_gen
    import sam_pkg::*;
#(
    parameter int DIV_SLOW  = 16,
    parameter int DIV_FAST  = 8,
    parameter int DIV_TURBO = 4,
    parameter int CW        = $clog2(DIV_SLOW)
) (
    input  logic          OSCOut,
    input  logic          RES,
    sam_ecq_gen_if.slave  bus
);

    localparam logic [CW:0] LEN_SLOW  = DIV_SLOW[CW:0];
    localparam logic [CW:0] LEN_FAST  = DIV_FAST[CW:0];
    localparam logic [CW:0] LEN_TURBO = DIV_TURBO[CW:0];

    function automatic logic [CW:0] div_len(input div_code_t code);
        case (code)
            DIV_CODE_FAST:  return LEN_FAST;
            DIV_CODE_TURBO: return LEN_TURBO;
            default:        return LEN_SLOW;
        endcase
    endfunction

    logic [CW-1:0] phase;
    logic [CW-1:0] nxt_phase;
    div_code_t     cur_div;
    div_code_t     nxt_div;
    div_code_t     sel_div;
    logic          e_r;
    logic          q_r;
    logic          start_r;
    logic [CW:0]   len_cur;
    logic [CW:0]   len_nxt;
    logic [CW:0]   nxt_ext;
    logic          last;

    sam_rate_sel u_rate_sel (
        .rate     (bus.RATE),
        .addr     (bus.A),
        .div_code (sel_div)
    );

    assign len_cur = div_len(cur_div);
    assign last    = ({1'b0, phase} == (len_cur - 1'b1));

    // The divider is only re-evaluated on an unstretched last tick.
    always_comb begin
        nxt_phase = phase + 1'b1;
        nxt_div   = cur_div;
        if (last) begin
            if (bus.STRETCH) begin
                nxt_phase = phase;
            end else begin
                nxt_phase = '0;
                nxt_div   = sel_div;
            end
        end
    end

    assign len_nxt = div_len(nxt_div);
    assign nxt_ext = {1'b0, nxt_phase};

    // E and Q decode the next phase so they change on the same edge as PHASE.
    always_ff @(posedge OSCOut) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (RES) begin
            phase   <= '0;
            cur_div <= DIV_CODE_SLOW;
            e_r     <= 1'b0;
            q_r     <= 1'b0;
            start_r <= 1'b1;
        end else begin
            phase   <= nxt_phase;
            cur_div <= nxt_div;
            e_r     <= (nxt_ext >= (len_nxt >> 1));
            q_r     <= (nxt_ext >= (len_nxt >> 2)) && (nxt_ext < (len_nxt - (len_nxt >> 2)));
            start_r <= (nxt_phase == '0);
        end
    end

    assign bus.E         = e_r;
    assign bus.Q         = q_r;
    assign bus.CYC_START = start_r;
    assign bus.CYC_END   = last && !bus.STRETCH;
    assign bus.PHASE     = phase;
    assign bus.CUR_DIV   = cur_div;

endmodule

// File: tb/tb_sam_ecq_gen.sv
// Directed bench for sam_ecq_gen: expected cycles are queued as stimulus is
// planned and popped while each DUT cycle is walked tick by tick.
module tb_sam_ecq_gen;
    import sam_pkg::*;

    typedef struct {
        int         n;
        int         k;
        logic [1:0] div;
    } cyc_t;

    logic        osc;
    logic        res;
    logic [1:0]  rate;
    logic [15:0] a;
    logic        stretch;
    bit          sel;
    int          total;
    int          bad;
    cyc_t        exp_q[$];

    logic [5:0]  obs_phase;
    logic        obs_e;
    logic        obs_q;
    logic        obs_cs;
    logic        obs_ce;
    logic [1:0]  obs_div;

    sam_ecq_gen_if #(.CW(4)) bus16 ();
    sam_ecq_gen_if #(.CW(5)) bus32 ();

    assign bus16.RATE    = rate;
    assign bus16.A       = a;
    assign bus16.STRETCH = stretch;
    assign bus32.RATE    = rate;
    assign bus32.A       = a;
    assign bus32.STRETCH = stretch;

    sam_ecq_gen #(.DIV_SLOW(16), .DIV_FAST(8), .DIV_TURBO(4)) dut16 (
        .OSCOut (osc),
        .RES    (res),
        .bus    (bus16)
    );

    sam_ecq_gen #(.DIV_SLOW(32), .DIV_FAST(16), .DIV_TURBO(8)) dut32 (
        .OSCOut (osc),
        .RES    (res),
        .bus    (bus32)
    );

    initial osc = 1'b0;
    always #5 osc = ~osc;

    always_comb begin
        if (sel) begin
            obs_phase = {1'b0, bus32.PHASE};
            obs_e     = bus32.E;
            obs_q     = bus32.Q;
            obs_cs    = bus32.CYC_START;
            obs_ce    = bus32.CYC_END;
            obs_div   = bus32.CUR_DIV;
        end else begin
            obs_phase = {2'b00, bus16.PHASE};
            obs_e     = bus16.E;
            obs_q     = bus16.Q;
            obs_cs    = bus16.CYC_START;
            obs_ce    = bus16.CYC_END;
            obs_div   = bus16.CUR_DIV;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int n, input int k, input logic [1:0] div);
        cyc_t c;
        c.n   = n;
        c.k   = k;
        c.div = div;
        exp_q.push_back(c);
    endtask

    task automatic do_reset();
        res = 1'b1;
        repeat (3) begin
            @(posedge osc); #1;
        end
        @(negedge osc);
        check("reset.phase", 32'(obs_phase), 32'd0);
        check("reset.e",     32'(obs_e),     32'd0);
        check("reset.q",     32'(obs_q),     32'd0);
        check("reset.cs",    32'(obs_cs),    32'd1);
        check("reset.ce",    32'(obs_ce),    32'd0);
        check("reset.div",   32'(obs_div),   32'd0);
        res = 1'b0;
    endtask

    // Walk one cycle; cont means its p=0 tick is already the current tick.
    task automatic run_cycle(input string lbl, input bit cont, input int chg_p,
                             input logic [1:0] chg_rate, input logic [15:0] chg_a,
                             input int st_p, input int st_len);
        cyc_t  ex;
        int    len;
        int    ep;
        string pre;
        if (exp_q.size() == 0) begin
            check({lbl, ".scoreboard_empty"}, 32'd1, 32'd0);
            return;
        end
        ex  = exp_q.pop_front();
        len = ex.n + ex.k;
        for (int t = 0; t < len; t++) begin
            if (!(cont && t == 0)) begin
                @(posedge osc); #1;
            end
            if (t == chg_p) begin
                rate = chg_rate;
                a    = chg_a;
            end
            stretch = (st_p >= 0) && (t >= st_p) && (t < st_p + st_len);
            if (cont && t == 0) #1;
            else @(negedge osc);
            ep  = (t < ex.n) ? t : ex.n - 1;
            pre = $sformatf("%s.t%0d", lbl, t);
            check({pre, ".phase"}, 32'(obs_phase), 32'(ep));
            check({pre, ".e"},     32'(obs_e),     32'(ep >= ex.n / 2));
            check({pre, ".q"},     32'(obs_q),     32'((ep >= ex.n / 4) && (ep < 3 * ex.n / 4)));
            check({pre, ".cs"},    32'(obs_cs),    32'(t == 0));
            check({pre, ".ce"},    32'(obs_ce),    32'(t == len - 1));
            check({pre, ".div"},   32'(obs_div),   32'(ex.div));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        total   = 0;
        bad     = 0;
        sel     = 1'b0;
        res     = 1'b1;
        rate    = RATE_SLOW;
        a       = 16'h0000;
        stretch = 1'b0;

        // Reset and default slow rate.
        do_reset();
        push_exp(16, 0, 2'b00);
        run_cycle("slow0", 1'b1, -1, RATE_SLOW, 16'h0000, -1, 0);

        // Turbo requested mid-cycle: current cycle keeps 16 ticks.
        push_exp(16, 0, 2'b00);
        run_cycle("to_turbo", 1'b0, 5, RATE_TURBO, 16'h0000, -1, 0);
        push_exp(4, 0, 2'b11);
        run_cycle("turbo0", 1'b0, -1, RATE_TURBO, 16'h0000, -1, 0);
        push_exp(4, 0, 2'b11);
        run_cycle("turbo1", 1'b0, 1, RATE_ADDR, 16'hC000, -1, 0);

        // Address-dependent mode: ROM fast, I/O page and RAM slow.
        push_exp(8, 0, 2'b10);
        run_cycle("addr_c000", 1'b0, 2, RATE_ADDR, 16'hFF20, -1, 0);
        push_exp(16, 0, 2'b00);
        run_cycle("addr_ff20", 1'b0, 3, RATE_ADDR, 16'h4000, -1, 0);
        push_exp(16, 0, 2'b00);
        run_cycle("addr_4000", 1'b0, 3, RATE_FAST, 16'h4000, -1, 0);

        // Stretch at the last phase, then a stretch pulse mid-cycle.
        push_exp(8, 3, 2'b10);
        run_cycle("stretch3", 1'b0, -1, RATE_FAST, 16'h4000, 7, 3);
        push_exp(8, 0, 2'b10);
        run_cycle("stretch_mid", 1'b0, -1, RATE_FAST, 16'h4000, 3, 1);

        // Reset arriving on the second stretch tick.
        for (int t = 0; t < 8; t++) begin
            @(posedge osc); #1;
            stretch = (t == 7);
            @(negedge osc);
            check($sformatf("rst_stretch.t%0d.phase", t), 32'(obs_phase), 32'(t));
        end
        @(posedge osc); #1;
        res = 1'b1;
        @(negedge osc);
        check("rst_stretch.hold.phase", 32'(obs_phase), 32'd7);
        check("rst_stretch.hold.e",     32'(obs_e),     32'd1);
        check("rst_stretch.hold.ce",    32'(obs_ce),    32'd0);
        @(posedge osc); #1;
        res     = 1'b0;
        stretch = 1'b0;
        rate    = RATE_SLOW;
        @(negedge osc);
        check("rst_stretch.phase", 32'(obs_phase), 32'd0);
        check("rst_stretch.e",     32'(obs_e),     32'd0);
        check("rst_stretch.q",     32'(obs_q),     32'd0);
        check("rst_stretch.div",   32'(obs_div),   32'd0);
        push_exp(16, 0, 2'b00);
        run_cycle("post_rst", 1'b1, -1, RATE_SLOW, 16'h0000, -1, 0);

        // Wider instance: sweep every RATE code.
        sel  = 1'b1;
        rate = RATE_SLOW;
        a    = 16'h0000;
        do_reset();
        push_exp(32, 0, 2'b00);
        run_cycle("w_slow", 1'b1, 3, RATE_FAST, 16'h0000, -1, 0);
        push_exp(16, 0, 2'b10);
        run_cycle("w_fast", 1'b0, 3, RATE_TURBO, 16'h0000, -1, 0);
        push_exp(8, 0, 2'b11);
        run_cycle("w_turbo", 1'b0, 3, RATE_ADDR, 16'h8000, -1, 0);
        push_exp(16, 0, 2'b10);
        run_cycle("w_addr", 1'b0, 3, RATE_SLOW, 16'h8000, -1, 0);
        push_exp(32, 0, 2'b00);
        run_cycle("w_slow2", 1'b0, -1, RATE_SLOW, 16'h8000, -1, 0);

        check("scoreboard.drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sam_ecq_gen.md
# sam_ecq_gen

Parametrised CPU clock-phase generator for the SAMx4 core. It derives the 6809 E and Q quadrature clocks and cycle strobes from the master oscillator, and supports slow, address-dependent, fast and turbo rates. Rate changes take effect only at cycle boundaries. A stretch input lengthens the E-high phase for slow peripherals. It sits between the oscillator input and the CPU/DRAM sequencing logic inside samxtop.

## Interface
- DIV_SLOW, 16, oscillator ticks per slow CPU cycle; multiple of 4, at least 8
- DIV_FAST, 8, ticks per fast cycle; multiple of 4, less than or equal to DIV_SLOW
- DIV_TURBO, 4, ticks per turbo cycle; multiple of 4, less than or equal to DIV_FAST
- CW, $clog2(DIV_SLOW), phase counter width
- OSCOut  in  1  master clock; all logic on its rising edge
- RES  in  1  reset; synchronous and active-high
- RATE  in  2  requested mode: 00 slow, 01 address-dependent, 10 fast, 11 turbo
- A  in  16  CPU address, used by mode 01 only
- STRETCH  in  1  high requests one extra E-high tick
- E  out  1  CPU E clock, registered
- Q  out  1  CPU Q clock, registered; leads E by a quarter cycle
- CYC_START  out  1  one-tick pulse on phase 0
- CYC_END  out  1  one-tick pulse on the last tick of a cycle
- PHASE  out  CW  current phase count
- CUR_DIV  out  2  effective divider of the current cycle: 00 slow, 10 fast, 11 turbo

## Operation
- Phase counter p runs 0..N-1, where N is the divider latched for the current cycle.
- Q is 1 for p in [N/4, 3N/4). E is 1 for p in [N/2, N).
- E and Q are registered from the next-state decode, so they are valid on the same edge as PHASE (no extra lag).
- Divider selection happens on the tick where p == N-1 and no stretch is being applied. N for the next cycle comes from the RATE value at that tick:
  - 00 → DIV_SLOW
  - 10 → DIV_FAST
  - 11 → DIV_TURBO
  - 01 → DIV_FAST if A[15]=1 and A[15:8]≠FF (ROM/cartridge); otherwise DIV_SLOW (RAM and the FFxx I/O page)
- RATE or A changes at any other tick have no effect on the current cycle.
- Stretch: at p == N-1, if STRETCH=1, p holds at N-1.
  - E stays 1, CYC_END stays 0, and the divider is not re-evaluated.
  - When STRETCH drops, CYC_END pulses on that tick and p goes to 0 on the next tick.
  - STRETCH is ignored at all other phases.
- CYC_START = 1 exactly when p == 0.
- CUR_DIV encodes the latched N, never the raw RATE input.

## Timing
- Reset (RES=1 at an edge) has priority over everything, including mid-cycle and mid-stretch. After that edge:
  - p=0, N=DIV_SLOW, CUR_DIV=00
  - E=0, Q=0, CYC_END=0
  - CYC_START=1, since p==0
- First edge after RES drops: p=1.
- Unstretched cycles are exactly N ticks.
- Q rises at p=N/4. E rises at p=N/2. Q falls at p=3N/4. E falls at p=0 of the next cycle.
- A stretch of k ticks extends the cycle to N+k ticks. E high time becomes N/2+k.
- Mode changes are glitch-free: no E or Q pulse is ever shorter than DIV_TURBO/4 ticks.
- CYC_END and CYC_START are never high on the same tick.
- Latency from a RATE change to the new period: the remainder of the current cycle, then the new N.

## Structure
- Shared package sam_pkg holds:
  - the rate encodings (RATE_SLOW=2'b00, RATE_ADDR=2'b01, RATE_FAST=2'b10, RATE_TURBO=2'b11)
  - the I/O page constant 8'hFF
- sub-module sam_rate_sel: combinational mapping of RATE and A to a divider code. It is reused by the DRAM refresh scheduler.
- The top level contains only the counter, stretch hold, divider latch and output registers.

## Test plan
- Reset and default rate: RES high for 3 ticks, then RATE=00 → E period 16 ticks; Q rises at p=4, E at p=8, Q falls at p=12; CYC_START at p=0; CUR_DIV=00.
- Turbo switch mid-cycle: RATE changes 00→11 at p=5 → current cycle still lasts 16 ticks; following cycles last 4 ticks; CUR_DIV=11 from the p=0 after the switch.
- Address-dependent mode (RATE=01):
  - A=C000 at the boundary → next cycle 8 ticks
  - A=FF20 → 16 ticks
  - A=4000 → 16 ticks
- Stretch: RATE=10, STRETCH high for 3 ticks starting at p=7 → cycle lasts 11 ticks, E high for 7 ticks, a single CYC_END on the tick STRETCH drops. STRETCH pulsed at p=3 → no effect.
- Reset mid-stretch: RES asserted on the second stretch tick → next edge p=0, E=0, Q=0, CUR_DIV=00.
- Generic widths: instantiate with DIV_SLOW=32, DIV_FAST=16, DIV_TURBO=8 and sweep all RATE codes → periods 32/16/8 ticks, quarter-phase edges at N/4 multiples.
